// File: rtl/trace_display.sv
// Multi-channel scrolling waveform renderer: per-channel circular sample buffer,
// two-stage pixel pipeline drawing joined traces with saturating colour mixing.
module trace_display #(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 1024,
  parameter int H_ACTIVE     = 1024,
  parameter int TOP          = 192,
  parameter int BOTTOM       = 576,
  parameter int THICKNESS    = 3,
  parameter logic [CHANNELS*12-1:0] COLORS = {12'hF00, 12'h00F}
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
  input  logic                             sample_valid,
  input  logic                             freeze,
  input  logic [CHANNELS-1:0]              channel_enable,
  input  logic [10:0]                      hcount,
  input  logic [9:0]                       vcount,
  input  logic                             at_display_area,
  output logic [3:0]                       r_out,
  output logic [3:0]                       g_out,
  output logic [3:0]                       b_out,
  output logic                             frozen,
  output logic [$clog2(DEPTH):0]           fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = CHANNELS * SAMPLE_WIDTH;
  localparam logic [AW:0]         FULL  = (AW+1)'(DEPTH);
  localparam logic [31:0]         SPAN  = 32'(BOTTOM - TOP);
  localparam logic signed [31:0]  BELOW = 32'((THICKNESS - 1) / 2);
  localparam logic signed [31:0]  ABOVE = 32'(THICKNESS / 2);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          col_valid;

  // stage 1
  logic [DW-1:0] rd_data;
  logic [9:0]    v_d;
  logic          de_d;
  logic          valid_d;
  logic          hzero_d;

  // stage 2
  logic signed [31:0] y_cur  [CHANNELS];
  logic signed [31:0] y_prev [CHANNELS];
  logic               prev_valid;
  logic signed [31:0] row;
  logic [31:0]        prod;
  logic signed [31:0] y_join;
  logic signed [31:0] lo;
  logic signed [31:0] hi;
  logic [7:0]         r_sum, g_sum, b_sum;
  logic [3:0]         r_next, g_next, b_next;

  function automatic logic [3:0] sat4(input logic [7:0] s);
    return (s > 8'd15) ? 4'hF : s[3:0];
  endfunction

  assign wr_en     = sample_valid && !frozen;
  assign rd_addr   = wr_ptr - AW'(H_ACTIVE) + AW'(hcount);
  assign col_valid = (32'(fill_level) + 32'(hcount)) >= 32'(H_ACTIVE);
  assign row       = 32'(v_d);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      fill_level <= '0;
      frozen     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (fill_level != FULL) fill_level <= fill_level + (AW+1)'(1);
      end
      if (hcount == '0 && vcount == '0) frozen <= freeze;
    end
  end

  // Read and write share the edge, so a collision returns the pre-write word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      v_d     <= '0;
      de_d    <= 1'b0;
      valid_d <= 1'b0;
      hzero_d <= 1'b0;
    end else begin
      rd_data <= mem[rd_addr];
      v_d     <= vcount;
      de_d    <= at_display_area;
      valid_d <= col_valid;
      hzero_d <= (hcount == '0);
    end
  end

  always_comb begin
    r_sum  = '0;
    g_sum  = '0;
    b_sum  = '0;
    prod   = '0;
    y_join = '0;
    lo     = '0;
    hi     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      y_cur[c] = '0;
    end
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      prod     = 32'(rd_data[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]) * SPAN;
      y_cur[c] = BOTTOM - signed'(prod >> SAMPLE_WIDTH);
      // No joining on the first column or after an unwritten column.
      y_join   = (hzero_d || !prev_valid) ? y_cur[c] : y_prev[c];
      lo       = ((y_cur[c] < y_join) ? y_cur[c] : y_join) - BELOW;
      hi       = ((y_cur[c] > y_join) ? y_cur[c] : y_join) + ABOVE;
      if (valid_d && channel_enable[c] && row >= lo && row <= hi) begin
        r_sum = r_sum + 8'(COLORS[c*12+8 +: 4]);
        g_sum = g_sum + 8'(COLORS[c*12+4 +: 4]);
        b_sum = b_sum + 8'(COLORS[c*12   +: 4]);
      end
    end
    r_next = de_d ? sat4(r_sum) : '0;
    g_next = de_d ? sat4(g_sum) : '0;
    b_next = de_d ? sat4(b_sum) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
      prev_valid <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) y_prev[c] <= '0;
    end else begin
      r_out      <= r_next;
      g_out      <= g_next;
      b_out      <= b_next;
      prev_valid <= valid_d;
      for (int unsigned c = 0; c < CHANNELS; c++) y_prev[c] <= y_cur[c];
    end
  end

endmodule

// File: tb/tb_trace_display.sv
// Scoreboard bench for trace_display: a sample-history model predicts every
// pixel of scanned rows; two instances cover additive and saturating palettes.
module tb_trace_display;

  localparam logic [23:0] C1 = {12'h00F, 12'hF00};
  localparam logic [23:0] C2 = {12'hF00, 12'hF00};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        freeze = 1'b0;
  logic [1:0]  channel_enable = 2'b01;
  logic [10:0] hcount = 11'd1100;
  logic [9:0]  vcount = 10'd600;
  logic        at_display_area = 1'b0;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        fr1, fr2;
  logic [10:0] fl1, fl2;

  typedef struct {
    logic [11:0] c1;
    logic [11:0] c2;
    int          h;
    int          v;
  } exp_t;

  exp_t        q[$];
  logic [15:0] hist[$];
  bit          model_frozen = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  trace_display #(.COLORS(C1)) dut (
    .clock(clock), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .freeze(freeze), .channel_enable(channel_enable), .hcount(hcount), .vcount(vcount),
    .at_display_area(at_display_area), .r_out(r1), .g_out(g1), .b_out(b1),
    .frozen(fr1), .fill_level(fl1));

  trace_display #(.COLORS(C2)) dut2 (
    .clock(clock), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .freeze(freeze), .channel_enable(channel_enable), .hcount(hcount), .vcount(vcount),
    .at_display_area(at_display_area), .r_out(r2), .g_out(g2), .b_out(b2),
    .frozen(fr2), .fill_level(fl2));

  function automatic int ymap(input int s);
    return 576 - (s * 384) / 256;
  endfunction

  function automatic int exp_fill();
    return (hist.size() > 1024) ? 1024 : hist.size();
  endfunction

  function automatic logic [11:0] exp_pix(input int h, input int v, input logic [23:0] cols);
    int r, g, b, idx, y, yp, lo, hi;
    logic [15:0] w;
    logic [11:0] col;
    r = 0; g = 0; b = 0;
    for (int c = 0; c < 2; c++) begin
      idx = hist.size() - 1024 + h;
      if (channel_enable[c] && idx >= 0) begin
        w = hist[idx];
        y = ymap(int'(w[c*8 +: 8]));
        yp = y;
        if (h > 0 && idx > 0) begin
          w = hist[idx-1];
          yp = ymap(int'(w[c*8 +: 8]));
        end
        lo = ((y < yp) ? y : yp) - 1;
        hi = ((y > yp) ? y : yp) + 1;
        if (v >= lo && v <= hi) begin
          col = cols[c*12 +: 12];
          r += int'(col[11:8]);
          g += int'(col[7:4]);
          b += int'(col[3:0]);
        end
      end
    end
    return {(r > 15) ? 4'hF : 4'(r), (g > 15) ? 4'hF : 4'(g), (b > 15) ? 4'hF : 4'(b)};
  endfunction

  task automatic reset_dut();
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    hist.delete();
    q.delete();
    model_frozen = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    sample_in = d;
    sample_valid = 1'b1;
    @(posedge clock); #1;
    sample_valid = 1'b0;
    if (!model_frozen) hist.push_back(d);
  endtask

  task automatic frame_start();
    hcount = '0; vcount = '0; at_display_area = 1'b0;
    @(posedge clock); #1;
    model_frozen = freeze;
    hcount = 11'd1100; vcount = 10'd600;
  endtask

  // Pixels are pushed as driven; outputs are popped two clocks later.
  task automatic scan_row(input int v, input int ncols, input bit flush);
    exp_t e;
    for (int i = 0; i < ncols + (flush ? 2 : 0); i++) begin
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if ({r1, g1, b1} !== e.c1 || {r2, g2, b2} !== e.c2) begin
          failures++;
          $display("FAIL pixel h=%0d v=%0d got=%h/%h expected=%h/%h",
                   e.h, e.v, {r1, g1, b1}, {r2, g2, b2}, e.c1, e.c2);
        end
      end
      if (i < ncols) begin
        hcount = 11'(i); vcount = 10'(v); at_display_area = 1'b1;
        e.c1 = exp_pix(i, v, C1); e.c2 = exp_pix(i, v, C2); e.h = i; e.v = v;
      end else begin
        hcount = 11'd1100; at_display_area = 1'b0;
        e.c1 = '0; e.c2 = '0; e.h = -1; e.v = v;
      end
      q.push_back(e);
      @(posedge clock); #1;
    end
    if (flush) q.delete();
    hcount = 11'd1100; vcount = 10'd600; at_display_area = 1'b0;
  endtask

  task automatic check_status(input string name);
    checks++;
    if (int'(fl1) != exp_fill() || fl2 !== fl1 || fr1 !== model_frozen || fr2 !== fr1) begin
      failures++;
      $display("FAIL %s fill=%0d/%0d frozen=%b/%b expected fill=%0d frozen=%b",
               name, fl1, fl2, fr1, fr2, exp_fill(), model_frozen);
    end
  endtask

  task automatic test_reset();
    @(posedge clock); @(posedge clock); #1;
    checks++;
    if ({r1, g1, b1, r2, g2, b2} !== '0) begin
      failures++;
      $display("FAIL reset_rgb got=%h/%h expected=000/000", {r1, g1, b1}, {r2, g2, b2});
    end
    checks++;
    if (fl1 !== 11'd0 || fr1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state fill=%0d frozen=%b expected 0/0", fl1, fr1);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fill_zero();
    reset_dut();
    channel_enable = 2'b01;
    for (int i = 0; i < 1024; i++) wr(16'h3000);
    check_status("fill_zero_status");
    foreach (hist[i]) if (i < 0) hist[i] = 0;
    scan_row(300, 1024, 1);
    scan_row(574, 1024, 1);
    scan_row(575, 1024, 1);
    scan_row(576, 1024, 1);
    scan_row(577, 1024, 1);
    scan_row(578, 1024, 1);
  endtask

  task automatic test_partial();
    reset_dut();
    for (int i = 0; i < 10; i++) wr(16'h00FF);
    check_status("partial_status");
    scan_row(192, 1024, 1);
    scan_row(193, 1024, 1);
    scan_row(195, 1024, 1);
    scan_row(196, 1024, 1);
    scan_row(300, 1024, 1);
  endtask

  task automatic test_alternating();
    reset_dut();
    for (int i = 0; i < 1024; i++) wr((i % 2 == 1) ? 16'h00FF : 16'h0000);
    check_status("alt_status");
    scan_row(192, 1024, 1);
    scan_row(193, 1024, 1);
    scan_row(400, 1024, 1);
    scan_row(577, 1024, 1);
    scan_row(578, 1024, 1);
  endtask

  task automatic test_overlap();
    reset_dut();
    channel_enable = 2'b11;
    for (int i = 0; i < 1030; i++) wr(16'h8080);
    check_status("overlap_status");
    scan_row(383, 1024, 1);
    scan_row(384, 1024, 1);
    scan_row(385, 1024, 1);
    scan_row(386, 1024, 1);
  endtask

  task automatic test_reset_mid();
    scan_row(384, 500, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({r1, g1, b1, r2, g2, b2} !== '0) begin
      failures++;
      $display("FAIL reset_mid_rgb got=%h/%h expected=000/000", {r1, g1, b1}, {r2, g2, b2});
    end
    q.delete();
    hist.delete();
    model_frozen = 1'b0;
    check_status("reset_mid_status");
    @(posedge clock); #1;
    reset_n = 1'b1;
    scan_row(384, 1024, 1);
    scan_row(576, 1024, 1);
  endtask

  task automatic test_freeze();
    channel_enable = 2'b01;
    for (int i = 0; i < 5; i++) wr(16'h0000);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) wr(16'h0000);
    check_status("freeze_pending");
    frame_start();
    check_status("freeze_latched");
    for (int i = 0; i < 4; i++) wr(16'h00FF);
    check_status("freeze_hold");
    freeze = 1'b0;
    for (int i = 0; i < 2; i++) wr(16'h00FF);
    check_status("unfreeze_pending");
    frame_start();
    check_status("unfreeze_latched");
    for (int i = 0; i < 2; i++) wr(16'h00FF);
    check_status("unfreeze_resume");
    scan_row(300, 1024, 1);
    scan_row(576, 1024, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_zero();
    test_partial();
    test_alternating();
    test_overlap();
    test_reset_mid();
    test_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
